// File: rtl/fusion_pkg.sv
`default_nettype none
// Shared frame geometry, destination codes and output-FSM states for the fusion output packer.
package fusion_pkg;

   localparam int IMAGE_WIDTH  = 520;
   localparam int IMAGE_HEIGHT = 520;
   localparam int IMAGE_SIZE   = IMAGE_WIDTH * IMAGE_HEIGHT;

   localparam logic DEST_AVG   = 1'b0;
   localparam logic DEST_FUSED = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_SEND_AVG   = 2'd1,
      ST_SEND_FUSED = 2'd2
   } out_state_e;

endpackage
`default_nettype wire

// File: rtl/fusion_lane_packer.sv
`default_nettype none
// Packs one byte per accepted beat into a little-endian word; lanes above the
// current one read as zero, so a flush on a partial word is zero-padded.
module fusion_lane_packer #(
   parameter int PIXELS_PER_WORD = 4
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 load_i,
   input  logic                                 flush_i,
   input  logic [$clog2(PIXELS_PER_WORD)-1:0]   lane_i,
   input  logic [7:0]                           byte_i,
   output logic [8*PIXELS_PER_WORD-1:0]         word_o
);

   import fusion_pkg::*;

   localparam int WORD_W = 8 * PIXELS_PER_WORD;

   logic [WORD_W-1:0] acc_q;
   logic [WORD_W-1:0] acc_d;
   logic [WORD_W-1:0] lane_byte;

   always_comb begin
      lane_byte = '0;
      lane_byte[{lane_i, 3'b000} +: 8] = byte_i;
   end

   // Upper lanes of acc_q are always zero, so OR-ing in the new byte is exact.
   assign word_o = acc_q | lane_byte;

   always_comb begin
      acc_d = acc_q;
      if (load_i) begin
         acc_d = flush_i ? '0 : word_o;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/fusion_output_packer.sv
`default_nettype none
// Splits {avg, fused} pixel beats into two byte planes, packs four pixels per
// word and emits each completed word as an avg/fused pair on one AXI stream.
module fusion_output_packer #(
   parameter int IMAGE_WIDTH     = fusion_pkg::IMAGE_WIDTH,
   parameter int IMAGE_HEIGHT    = fusion_pkg::IMAGE_HEIGHT,
   parameter int PIXELS_PER_WORD = 4
) (
   input  logic        axi_clk,
   input  logic        axi_reset,
   input  logic        s_axis_valid,
   input  logic [15:0] s_axis_input,
   input  logic        s_axis_last,
   output logic        s_axis_ready,
   output logic        m_axis_valid,
   output logic [31:0] m_axis_output,
   output logic        m_axis_dest,
   output logic        m_axis_last,
   input  logic        m_axis_ready,
   output logic        frame_done,
   output logic        len_error,
   output logic [15:0] frame_count
);

   import fusion_pkg::*;

   localparam int IMG_SIZE = IMAGE_WIDTH * IMAGE_HEIGHT;
   localparam int CNT_W    = $clog2(IMG_SIZE);
   localparam int LANE_W   = $clog2(PIXELS_PER_WORD);

   localparam logic [CNT_W-1:0]  LAST_PIX  = CNT_W'(IMG_SIZE - 1);
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PIXELS_PER_WORD - 1);

   out_state_e         state_q;
   out_state_e         state_d;
   logic [CNT_W-1:0]   count_q;
   logic [CNT_W-1:0]   count_d;
   logic               hold_valid_q;
   logic               hold_valid_d;
   logic               hold_last_q;
   logic               hold_last_d;
   logic [31:0]        hold_avg_q;
   logic [31:0]        hold_avg_d;
   logic [31:0]        hold_fused_q;
   logic [31:0]        hold_fused_d;
   logic               frame_done_q;
   logic               frame_done_d;
   logic               len_error_q;
   logic               len_error_d;
   logic [15:0]        frame_count_q;
   logic [15:0]        frame_count_d;

   logic [LANE_W-1:0]  byte_idx;
   logic               at_last_pix;
   logic               frame_end;
   logic               word_done;
   logic               accept;
   logic               fused_xfer;
   logic [31:0]        avg_word;
   logic [31:0]        fused_word;

   assign byte_idx    = count_q[LANE_W-1:0];
   assign at_last_pix = (count_q == LAST_PIX);
   assign frame_end   = s_axis_last | at_last_pix;
   assign word_done   = (byte_idx == LAST_LANE) | frame_end;

   // Only a word-completing beat needs the holding buffer, so only it can stall.
   assign s_axis_ready = ~axi_reset & ~(hold_valid_q & word_done);
   assign accept       = s_axis_valid & s_axis_ready;
   assign fused_xfer   = (state_q == ST_SEND_FUSED) & m_axis_ready;

   fusion_lane_packer #(
      .PIXELS_PER_WORD (PIXELS_PER_WORD)
   ) u_avg_packer (
      .clk     (axi_clk),
      .rst     (axi_reset),
      .load_i  (accept),
      .flush_i (word_done),
      .lane_i  (byte_idx),
      .byte_i  (s_axis_input[15:8]),
      .word_o  (avg_word)
   );

   fusion_lane_packer #(
      .PIXELS_PER_WORD (PIXELS_PER_WORD)
   ) u_fused_packer (
      .clk     (axi_clk),
      .rst     (axi_reset),
      .load_i  (accept),
      .flush_i (word_done),
      .lane_i  (byte_idx),
      .byte_i  (s_axis_input[7:0]),
      .word_o  (fused_word)
   );

   always_comb begin
      count_d       = count_q;
      hold_valid_d  = hold_valid_q;
      hold_last_d   = hold_last_q;
      hold_avg_d    = hold_avg_q;
      hold_fused_d  = hold_fused_q;
      len_error_d   = 1'b0;
      frame_done_d  = 1'b0;
      frame_count_d = frame_count_q;

      if (fused_xfer) begin
         hold_valid_d = 1'b0;
         if (hold_last_q) begin
            frame_done_d  = 1'b1;
            frame_count_d = frame_count_q + 16'd1;
         end
      end

      if (accept) begin
         count_d     = frame_end ? '0 : count_q + 1'b1;
         // Early end, or the final pixel arriving without its last flag.
         len_error_d = s_axis_last ^ at_last_pix;
         if (word_done) begin
            hold_valid_d = 1'b1;
            hold_last_d  = frame_end;
            hold_avg_d   = avg_word;
            hold_fused_d = fused_word;
         end
      end
   end

   always_ff @(posedge axi_clk) begin
      if (axi_reset) begin
         count_q       <= '0;
         hold_valid_q  <= 1'b0;
         hold_last_q   <= 1'b0;
         hold_avg_q    <= '0;
         hold_fused_q  <= '0;
         len_error_q   <= 1'b0;
         frame_done_q  <= 1'b0;
         frame_count_q <= '0;
      end else begin
         count_q       <= count_d;
         hold_valid_q  <= hold_valid_d;
         hold_last_q   <= hold_last_d;
         hold_avg_q    <= hold_avg_d;
         hold_fused_q  <= hold_fused_d;
         len_error_q   <= len_error_d;
         frame_done_q  <= frame_done_d;
         frame_count_q <= frame_count_d;
      end
   end

   always_ff @(posedge axi_clk) begin
      if (axi_reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (hold_valid_q) begin
               state_d = ST_SEND_AVG;
            end
         end
         ST_SEND_AVG: begin
            if (m_axis_ready) begin
               state_d = ST_SEND_FUSED;
            end
         end
         ST_SEND_FUSED: begin
            if (m_axis_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs come straight from the holding buffer, which cannot change while a word is presented.
   always_comb begin
      m_axis_valid  = 1'b0;
      m_axis_dest   = DEST_AVG;
      m_axis_last   = 1'b0;
      m_axis_output = '0;
      case (state_q)
         ST_SEND_AVG: begin
            m_axis_valid  = 1'b1;
            m_axis_dest   = DEST_AVG;
            m_axis_last   = hold_last_q;
            m_axis_output = hold_avg_q;
         end
         ST_SEND_FUSED: begin
            m_axis_valid  = 1'b1;
            m_axis_dest   = DEST_FUSED;
            m_axis_last   = hold_last_q;
            m_axis_output = hold_fused_q;
         end
         default: ;
      endcase
   end

   assign frame_done  = frame_done_q;
   assign len_error   = len_error_q;
   assign frame_count = frame_count_q;

endmodule
`default_nettype wire

// File: tb/tb_fusion_output_packer.sv
`default_nettype none
// Directed self-checking bench for fusion_output_packer on a reduced 8x2 frame.
module tb_fusion_output_packer;

   localparam int IW = 8;
   localparam int IH = 2;
   localparam int SZ = IW * IH;

   logic        axi_clk      = 1'b0;
   logic        axi_reset    = 1'b1;
   logic        s_axis_valid = 1'b0;
   logic [15:0] s_axis_input = '0;
   logic        s_axis_last  = 1'b0;
   logic        s_axis_ready;
   logic        m_axis_valid;
   logic [31:0] m_axis_output;
   logic        m_axis_dest;
   logic        m_axis_last;
   logic        m_axis_ready = 1'b1;
   logic        frame_done;
   logic        len_error;
   logic [15:0] frame_count;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int n_done   = 0;
   int n_lenerr = 0;
   logic [33:0] mon_q[$];

   fusion_output_packer #(
      .IMAGE_WIDTH     (IW),
      .IMAGE_HEIGHT    (IH),
      .PIXELS_PER_WORD (4)
   ) dut (
      .axi_clk       (axi_clk),
      .axi_reset     (axi_reset),
      .s_axis_valid  (s_axis_valid),
      .s_axis_input  (s_axis_input),
      .s_axis_last   (s_axis_last),
      .s_axis_ready  (s_axis_ready),
      .m_axis_valid  (m_axis_valid),
      .m_axis_output (m_axis_output),
      .m_axis_dest   (m_axis_dest),
      .m_axis_last   (m_axis_last),
      .m_axis_ready  (m_axis_ready),
      .frame_done    (frame_done),
      .len_error     (len_error),
      .frame_count   (frame_count)
   );

   always #5 axi_clk = ~axi_clk;

   always @(posedge axi_clk) cyc <= cyc + 1;

   // Handshake seen at this negedge completes on the following posedge.
   always @(negedge axi_clk) begin
      if (m_axis_valid && m_axis_ready) mon_q.push_back({m_axis_last, m_axis_dest, m_axis_output});
      if (frame_done) n_done <= n_done + 1;
      if (len_error) n_lenerr <= n_lenerr + 1;
   end

   task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] pix(input int i, input logic [7:0] base);
      logic [7:0] f;
      f = base + 8'(i);
      return {f + 8'h80, f};
   endfunction

   function automatic logic [31:0] wd(input logic [7:0] b);
      return {b + 8'd3, b + 8'd2, b + 8'd1, b};
   endfunction

   function automatic logic [33:0] got_word(input int idx);
      if (idx < mon_q.size()) return mon_q[idx];
      return 'x;
   endfunction

   task automatic send_beat(input logic [15:0] d, input logic l);
      int t = 0;
      s_axis_valid = 1'b1;
      s_axis_input = d;
      s_axis_last  = l;
      @(negedge axi_clk);
      while (!s_axis_ready && t < 100) begin
         t++;
         @(negedge axi_clk);
      end
      if (t >= 100) chk("beat_timeout", s_axis_ready, 1);
      @(posedge axi_clk);
      #1;
      s_axis_valid = 1'b0;
      s_axis_last  = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] base, input int n, input logic with_last);
      for (int i = 0; i < n; i++) send_beat(pix(i, base), with_last && (i == n - 1));
   endtask

   task automatic do_reset();
      @(posedge axi_clk);
      #1;
      axi_reset    = 1'b1;
      s_axis_valid = 1'b0;
      s_axis_last  = 1'b0;
      m_axis_ready = 1'b1;
      @(posedge axi_clk);
      #1;
      axi_reset = 1'b0;
   endtask

   task automatic wait_words(input int target);
      int t = 0;
      while (mon_q.size() < target && t < 200) begin
         @(posedge axi_clk);
         t++;
      end
      if (mon_q.size() < target) chk("word_timeout", mon_q.size(), target);
   endtask

   task automatic check_pair(input string tag, input int idx, input logic [7:0] fb, input logic last);
      chk({tag, "_avg"},   got_word(idx),     {last, 1'b0, wd(fb + 8'h80)});
      chk({tag, "_fused"}, got_word(idx + 1), {last, 1'b1, wd(fb)});
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1);
   end

   initial begin : stim
      int base;
      int d0;
      int e0;
      int c0;

      // Reset state
      repeat (3) @(posedge axi_clk);
      @(negedge axi_clk);
      chk("rst_sready", s_axis_ready, 0);
      chk("rst_outs", {m_axis_valid, m_axis_last, m_axis_dest, frame_done, len_error, m_axis_output}, 0);
      chk("rst_fcount", frame_count, 0);
      @(posedge axi_clk);
      #1;
      axi_reset = 1'b0;
      @(negedge axi_clk);
      chk("post_rst_sready", s_axis_ready, 1);
      @(posedge axi_clk);
      #1;

      // Basic pair with exact latency
      send_beat(16'hA001, 1'b0);
      send_beat(16'hA102, 1'b0);
      send_beat(16'hA203, 1'b0);
      send_beat(16'hA304, 1'b0);
      @(negedge axi_clk);
      chk("basic_latency", m_axis_valid, 0);
      @(negedge axi_clk);
      chk("basic_avg", {m_axis_valid, m_axis_dest, m_axis_last, m_axis_output}, {1'b1, 1'b0, 1'b0, 32'hA3A2A1A0});
      @(negedge axi_clk);
      chk("basic_fused", {m_axis_valid, m_axis_dest, m_axis_last, m_axis_output}, {1'b1, 1'b1, 1'b0, 32'h04030201});

      // Full frame at one pixel per cycle
      do_reset();
      base = mon_q.size(); d0 = n_done; e0 = n_lenerr;
      c0 = cyc;
      send_frame(8'h00, SZ, 1'b1);
      chk("full_rate", cyc - c0, SZ);
      wait_words(base + 8);
      repeat (4) @(posedge axi_clk);
      for (int k = 0; k < 4; k++) check_pair($sformatf("full%0d", k), base + 2 * k, 8'(4 * k), k == 3);
      chk("full_nwords", mon_q.size() - base, 8);
      chk("full_done", n_done - d0, 1);
      chk("full_fcount", frame_count, 1);
      chk("full_lenerr", n_lenerr - e0, 0);

      // Downstream backpressure mid-frame
      do_reset();
      base = mon_q.size();
      fork
         send_frame(8'h00, SZ, 1'b1);
         begin : bp_mon
            logic [34:0] snap;
            int saw_low;
            saw_low = 0;
            repeat (5) @(posedge axi_clk);
            #1;
            m_axis_ready = 1'b0;
            @(negedge axi_clk);
            snap = {m_axis_valid, m_axis_last, m_axis_dest, m_axis_output};
            chk("bp_held_word", snap, {1'b1, 1'b0, 1'b0, wd(8'h80)});
            for (int k = 0; k < 10; k++) begin
               @(negedge axi_clk);
               if (!s_axis_ready) saw_low = 1;
               chk($sformatf("bp_stable%0d", k), {m_axis_valid, m_axis_last, m_axis_dest, m_axis_output}, snap);
            end
            @(posedge axi_clk);
            #1;
            m_axis_ready = 1'b1;
            chk("bp_sready_low", saw_low, 1);
         end
      join
      wait_words(base + 8);
      repeat (4) @(posedge axi_clk);
      for (int k = 0; k < 4; k++) check_pair($sformatf("bp%0d", k), base + 2 * k, 8'(4 * k), k == 3);
      chk("bp_nwords", mon_q.size() - base, 8);

      // Early frame end at pixel 5
      do_reset();
      base = mon_q.size(); d0 = n_done; e0 = n_lenerr;
      send_frame(8'h00, 6, 1'b1);
      send_frame(8'h10, 4, 1'b0);
      wait_words(base + 6);
      repeat (4) @(posedge axi_clk);
      check_pair("early0", base, 8'h00, 1'b0);
      chk("early1_avg",   got_word(base + 2), {1'b1, 1'b0, 32'h00008584});
      chk("early1_fused", got_word(base + 3), {1'b1, 1'b1, 32'h00000504});
      check_pair("early_next", base + 4, 8'h10, 1'b0);
      chk("early_lenerr", n_lenerr - e0, 1);
      chk("early_done", n_done - d0, 1);

      // Reset after two beats of a word
      do_reset();
      base = mon_q.size();
      send_beat(pix(0, 8'h50), 1'b0);
      send_beat(pix(1, 8'h50), 1'b0);
      do_reset();
      send_frame(8'h20, 4, 1'b0);
      wait_words(base + 2);
      repeat (6) @(posedge axi_clk);
      chk("midrst_nwords", mon_q.size() - base, 2);
      check_pair("midrst", base, 8'h20, 1'b0);

      // Final pixel without its last flag
      do_reset();
      base = mon_q.size(); d0 = n_done; e0 = n_lenerr;
      send_frame(8'h00, SZ, 1'b0);
      send_frame(8'h30, 4, 1'b0);
      wait_words(base + 10);
      repeat (4) @(posedge axi_clk);
      check_pair("nolast2", base + 4, 8'h08, 1'b0);
      check_pair("nolast3", base + 6, 8'h0C, 1'b1);
      check_pair("nolast_next", base + 8, 8'h30, 1'b0);
      chk("nolast_lenerr", n_lenerr - e0, 1);
      chk("nolast_done", n_done - d0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fusion_output_packer.md
FUSION_OUTPUT_PACKER -- requirements
Module: fusion_output_packer

Interface
REQ-001 SHALL take parameters (one per line: name, default, meaning):
- IMAGE_WIDTH, 520, pixels per line
- IMAGE_HEIGHT, 520, lines per frame
- PIXELS_PER_WORD, 4, bytes packed per output word (fixed at 4)
REQ-002 SHALL have these ports (one per line: name, direction, width, meaning):
- axi_clk  in  1  single clock
- axi_reset  in  1  reset; synchronous, active-high
- s_axis_valid  in  1  fused-pixel beat valid
- s_axis_input  in  16  {avg[15:8], fused[7:0]}, one pixel
- s_axis_last  in  1  final pixel of frame
- s_axis_ready  out  1  beat accepted when valid&ready
- m_axis_valid  out  1  packed word valid
- m_axis_output  out  32  four packed bytes
- m_axis_dest  out  1  0 = avg plane, 1 = fused plane
- m_axis_last  out  1  final word of this plane for the frame
- m_axis_ready  in  1  downstream DMA ready
- frame_done  out  1  one-cycle pulse after final fused word transfers
- len_error  out  1  one-cycle pulse on frame-length mismatch
- frame_count  out  16  completed frames, wraps 0xFFFF->0

Function
REQ-003 SHALL demux each accepted beat: avg byte into the avg accumulator, fused byte into the fused accumulator, at byte lane byte_idx.
REQ-004 SHALL order lanes little-endian: pixel 4k at [7:0], pixel 4k+3 at [31:24].
REQ-005 SHALL count accepted pixels 0..IMAGE_WIDTH*IMAGE_HEIGHT-1 (19-bit for defaults); byte_idx = pixel count mod 4.
REQ-006 SHALL, on accepting lane 3 (or a frame-end beat), move both accumulators into a one-entry holding buffer in the same cycle.
REQ-007 SHALL run the output FSM IDLE -> SEND_AVG -> SEND_FUSED -> IDLE: SEND_AVG presents the avg word with dest=0; SEND_FUSED presents the fused word with dest=1. Each state advances only on m_axis_valid&m_axis_ready.
REQ-008 SHALL have a latency of 1 cycle: if the lane-3 beat is accepted at edge N, the avg word is valid after edge N+1. With ready held high, the fused word follows one cycle later.
REQ-009 SHALL hold m_axis_output, dest and last stable while valid is high and ready is low.
REQ-010 SHALL deassert s_axis_ready only when the holding buffer is occupied and the next beat would complete a word. Beats at lanes 0-2 are always accepted.
REQ-011 SHALL sustain 1 pixel/cycle when m_axis_ready is constantly high.
REQ-012 SHALL assert m_axis_last on both the avg and the fused word that contain the frame's final pixel.
REQ-013 SHALL treat an early frame end (s_axis_last with count < IMAGE_SIZE-1) as follows: zero-pad the unfilled lanes, flush, set last, pulse len_error, and reset count.
REQ-014 SHALL treat a missing frame end (count reaches IMAGE_SIZE-1 without s_axis_last) as a frame end: flush with last, pulse len_error, and reset count.
REQ-015 SHALL produce a correct frame end (s_axis_last at IMAGE_SIZE-1) with no len_error.
REQ-016 SHALL pulse frame_done and increment frame_count in the cycle after the last fused word handshake.

Reset
REQ-017 SHALL, with axi_reset high at a clock edge, clear: the FSM to IDLE, count, byte_idx, accumulators, holding buffer, frame_count, m_axis_valid, m_axis_last, m_axis_dest, m_axis_output, frame_done and len_error (all 0). s_axis_ready SHALL be 0 while in reset.
REQ-018 SHALL drop any partially packed or pending word on reset mid-frame. The first beat after reset is pixel 0.

Structure
REQ-019 SHALL place the shared package constants fusion_pkg: IMAGE_WIDTH, IMAGE_HEIGHT, IMAGE_SIZE, DEST_AVG=0, DEST_FUSED=1, and the FSM state enum.
REQ-020 SHALL contain exactly one sub-module, fusion_lane_packer (4-byte shift/pack register with zero-pad flush), instantiated twice (avg, fused).

Verification
REQ-021 SHALL cover a stream of 4 beats 0xA001,0xA102,0xA203,0xA304 with ready high: word 0xA3A2A1A0 with dest=0 one cycle after beat 4, then 0x04030201 with dest=1 on the next cycle.
REQ-022 SHALL cover a full 520x520 frame with last on pixel 270399: 67600 word pairs; last on the final pair only; one frame_done; frame_count=1; no len_error.
REQ-023 SHALL cover m_axis_ready low for 10 cycles mid-frame: s_axis_ready drops at the lane-3 beat; outputs stay stable; no pixel is lost or duplicated (compared against a scoreboard).
REQ-024 SHALL cover an early s_axis_last at pixel 5 (lane 1): second pair holds lanes 2-3 = 0x00 with last=1; len_error pulses once; the next frame starts at lane 0.
REQ-025 SHALL cover axi_reset asserted for 1 cycle after 2 beats of a word: no output word is emitted; the following 4 beats produce a clean pair.
REQ-026 SHALL cover 270400 beats without s_axis_last: a flush with last=1 and a len_error pulse, then counting restarts.
